// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings, opcode/funct
// constants, ALUOp and ALUControl codes. Reused by the datapath and the bench.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. The controller uses the slave modport, the datapath the master.
interface multicycle_control_if #(
    parameter int STW = 4
);
    logic [5:0]     Opcode;
    logic [5:0]     Funct;
    logic           Zero;
    logic           MemReady;
    logic           IorD;
    logic           MemWrite;
    logic           IRWrite;
    logic           RegDst;
    logic           MemtoReg;
    logic           RegWrite;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     PCSrc;
    logic           PCEn;
    logic [2:0]     ALUControl;
    logic           IllegalOp;
    logic [STW-1:0] State;

    modport slave (
        input  Opcode, Funct, Zero, MemReady,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State
    );

    modport master (
        output Opcode, Funct, Zero, MemReady,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps ALUOp and Funct to the 3-bit ALUControl code. Unknown Funct falls back to add.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control
);
    always_comb begin
        alu_control = ALUCTL_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUCTL_ADD;
                    FN_SUB:  alu_control = ALUCTL_SUB;
                    FN_AND:  alu_control = ALUCTL_AND;
                    FN_OR:   alu_control = ALUCTL_OR;
                    FN_SLT:  alu_control = ALUCTL_SLT;
                    default: alu_control = ALUCTL_ADD;
                endcase
            end
            default: alu_control = ALUCTL_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller (Moore FSM + PC enable + ALU decode).
// Optional ADDI support is built when MC_CTRL_ADDI_EN is defined.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int STW = 4
)(
    input  logic CLK,
    input  logic Reset,
    multicycle_control_if.slave bus
);
    logic [STW-1:0] state_reg;
    state_t         state_cur;
    state_t         state_next;
    logic           state_ext_ok;

    logic   iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
    logic   pc_write, branch, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    aluop_t aluop;
    logic [2:0] alu_control;

    // Any set bit above the 4-bit encoding marks an unreachable state.
    generate
        if (STW > 4) begin : g_wide
            assign state_ext_ok = ~|state_reg[STW-1:4];
        end else begin : g_narrow
            assign state_ext_ok = 1'b1;
        end
    endgenerate

    assign state_cur = state_t'(state_reg[3:0]);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= STW'(S_FETCH);
        end else begin
            state_reg <= STW'(state_next);
        end
    end

    always_comb begin
        state_next = S_FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        if (state_ext_ok) begin
            case (state_cur)
                S_FETCH: begin
                    alu_src_b  = 2'b01;
                    ir_write   = bus.MemReady;
                    pc_write   = bus.MemReady;
                    state_next = bus.MemReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Branch target computed here while the opcode is decoded.
                    alu_src_b = 2'b11;
                    case (bus.Opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYPE:     state_next = S_EXECUTE;
                        OP_BEQ:       state_next = S_BRANCH;
                        OP_J:         state_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                        OP_ADDI:      state_next = S_ADDIEX;
`endif
                        default: begin
                            illegal_op = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (bus.Opcode == OP_LW) begin
                        state_next = S_MEMREAD;
                    end else if (bus.Opcode == OP_SW) begin
                        state_next = S_MEMWRITE;
                    end
                end
                S_MEMREAD: begin
                    iord       = 1'b1;
                    state_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    memto_reg = 1'b1;
                    reg_write = 1'b1;
                end
                S_MEMWRITE: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a  = 1'b1;
                    aluop      = ALUOP_FUNCT;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    aluop     = ALUOP_SUB;
                    pc_src    = 2'b01;
                    branch    = 1'b1;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
`ifdef MC_CTRL_ADDI_EN
                S_ADDIEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
`endif
                default: state_next = S_FETCH;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (bus.Funct),
        .alu_control (alu_control)
    );

    // Write strobes are gated by reset so nothing commits while it is held low.
    assign bus.IorD       = iord;
    assign bus.MemWrite   = Reset & mem_write;
    assign bus.IRWrite    = Reset & ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = memto_reg;
    assign bus.RegWrite   = Reset & reg_write;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.PCSrc      = pc_src;
    assign bus.PCEn       = Reset & (pc_write | (branch & bus.Zero));
    assign bus.ALUControl = alu_control;
    assign bus.IllegalOp  = illegal_op;
    assign bus.State      = state_reg;

endmodule
